// File: rtl/issue_queue_mp.sv
// Multi-push / multi-pop circular issue queue; pushes are all-or-nothing against registered free space.
// Head entries are read combinationally (0-cycle); a push becomes visible on out_data the next cycle.
module issue_queue_mp #(
   parameter int ELEM_W = 64,
   parameter int DEPTH  = 16,
   parameter int PUSH_W = 4,
   parameter int POP_W  = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic [PUSH_W*ELEM_W-1:0]         in_data,
   input  logic [$clog2(PUSH_W+1)-1:0]      in_data_number,
   output logic [$clog2(DEPTH+1)-1:0]       iq_size_left,
   output logic [POP_W*ELEM_W-1:0]          out_data,
   output logic [$clog2(POP_W+1)-1:0]       iq_size,
   input  logic [$clog2(POP_W+1)-1:0]       out_data_number,
   output logic                             push_overflow,
   output logic                             pop_underflow,
   output logic [$clog2(DEPTH+1)-1:0]       peak_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int NW = $clog2(PUSH_W+1);
   localparam int PW = $clog2(POP_W+1);

   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [ELEM_W-1:0] storage [DEPTH];

   logic              push_ok;
   logic              pop_bad;
   logic [CW-1:0]     n_acc;
   logic [CW-1:0]     pop_eff;
   logic [CW-1:0]     count_next;

   // Capacity is judged on the registered count only, so a same-cycle pop never frees room for a push.
   always_comb begin
      iq_size_left = CW'(DEPTH) - count;
      iq_size      = (count >= CW'(POP_W)) ? PW'(POP_W) : PW'(count);
      push_ok      = CW'(in_data_number) <= iq_size_left;
      n_acc        = push_ok ? CW'(in_data_number) : '0;
      pop_bad      = out_data_number > iq_size;
      pop_eff      = pop_bad ? CW'(iq_size) : CW'(out_data_number);
      count_next   = count + n_acc - pop_eff;
   end

   for (genvar k = 0; k < POP_W; k++) begin : g_out
      assign out_data[k*ELEM_W +: ELEM_W] = storage[head + AW'(k)];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         peak_count    <= '0;
         push_overflow <= 1'b0;
         pop_underflow <= 1'b0;
      end else if (flush) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         peak_count <= '0;
      end else begin
         head       <= head + AW'(pop_eff);
         tail       <= tail + AW'(n_acc);
         count      <= count_next;
         peak_count <= (count_next > peak_count) ? count_next : peak_count;
         if (!push_ok) push_overflow <= 1'b1;
         if (pop_bad)  pop_underflow <= 1'b1;
      end
   end

   // Storage is not cleared by flush; stale entries sit outside the valid window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      end else if (!flush && push_ok) begin
         for (int i = 0; i < PUSH_W; i++) begin
            if (NW'(i) < in_data_number)
               storage[tail + AW'(i)] <= in_data[i*ELEM_W +: ELEM_W];
         end
      end
   end

endmodule

// File: tb/tb_issue_queue_mp.sv
// Directed bench for issue_queue_mp: hand-computed vectors covering fill, overflow, wrap,
// concurrent push/pop, underflow, flush and asynchronous reset.
module tb_issue_queue_mp;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic [255:0] in_data;
   logic [2:0]   in_data_number;
   logic [4:0]   iq_size_left;
   logic [127:0] out_data;
   logic [1:0]   iq_size;
   logic [1:0]   out_data_number;
   logic         push_overflow;
   logic         pop_underflow;
   logic [4:0]   peak_count;

   int vecs = 0;
   int errs = 0;

   issue_queue_mp #(.ELEM_W(64), .DEPTH(16), .PUSH_W(4), .POP_W(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .in_data        (in_data),
      .in_data_number (in_data_number),
      .iq_size_left   (iq_size_left),
      .out_data       (out_data),
      .iq_size        (iq_size),
      .out_data_number(out_data_number),
      .push_overflow  (push_overflow),
      .pop_underflow  (pop_underflow),
      .peak_count     (peak_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: push n consecutive values from base, pop p, optional flush; inputs cleared afterwards.
   task automatic pp(input int n, input int p, input logic [63:0] base, input logic fl = 1'b0);
      in_data = '0;
      for (int i = 0; i < n; i++) in_data[i*64 +: 64] = base + 64'(i);
      in_data_number  = 3'(n);
      out_data_number = 2'(p);
      flush           = fl;
      @(posedge clk);
      #1;
      in_data_number  = '0;
      out_data_number = '0;
      flush           = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      in_data = '0;
      in_data_number = '0;
      out_data_number = '0;
      #12;
      chk("rst_left", 64'(iq_size_left), 64'd16);
      chk("rst_size", 64'(iq_size), 64'd0);
      chk("rst_out", out_data[63:0] | out_data[127:64], 64'd0);
      chk("rst_ovf", 64'(push_overflow), 64'd0);
      chk("rst_udf", 64'(pop_underflow), 64'd0);
      chk("rst_peak", 64'(peak_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // first push of four
      pp(4, 0, 64'h101);
      chk("t1_size", 64'(iq_size), 64'd2);
      chk("t1_slot0", out_data[63:0], 64'h101);
      chk("t1_slot1", out_data[127:64], 64'h102);
      chk("t1_left", 64'(iq_size_left), 64'd12);
      chk("t1_peak", 64'(peak_count), 64'd4);

      // fill to full, then over-push with concurrent pop
      pp(4, 0, 64'h105);
      pp(4, 0, 64'h109);
      pp(4, 0, 64'h10d);
      chk("t2_full_left", 64'(iq_size_left), 64'd0);
      chk("t2_full_peak", 64'(peak_count), 64'd16);
      chk("t2_full_ovf", 64'(push_overflow), 64'd0);
      pp(1, 2, 64'h1ff);
      chk("t2_ovf", 64'(push_overflow), 64'd1);
      chk("t2_left", 64'(iq_size_left), 64'd2);
      chk("t2_slot0", out_data[63:0], 64'h103);
      chk("t2_slot1", out_data[127:64], 64'h104);
      chk("t2_peak", 64'(peak_count), 64'd16);
      chk("t2_udf", 64'(pop_underflow), 64'd0);

      // drive head/tail to 14 with an empty queue, then wrap
      do_reset();
      chk("t3_rst_ovf", 64'(push_overflow), 64'd0);
      pp(4, 0, 64'h200);
      pp(4, 2, 64'h204);
      chk("t3_c2_slot0", out_data[63:0], 64'h202);
      chk("t3_c2_slot1", out_data[127:64], 64'h203);
      pp(4, 2, 64'h208);
      chk("t3_c3_slot0", out_data[63:0], 64'h204);
      pp(2, 2, 64'h20c);
      for (int i = 0; i < 4; i++) pp(0, 2, 64'h0);
      chk("t3_empty_size", 64'(iq_size), 64'd0);
      chk("t3_empty_left", 64'(iq_size_left), 64'd16);
      chk("t3_peak", 64'(peak_count), 64'd8);
      pp(4, 0, 64'h300);
      chk("t3_w_size", 64'(iq_size), 64'd2);
      chk("t3_w_slot0", out_data[63:0], 64'h300);
      chk("t3_w_slot1", out_data[127:64], 64'h301);
      chk("t3_w_left", 64'(iq_size_left), 64'd12);
      pp(0, 2, 64'h0);
      chk("t3_w2_slot0", out_data[63:0], 64'h302);
      chk("t3_w2_slot1", out_data[127:64], 64'h303);
      pp(0, 2, 64'h0);
      chk("t3_drain", 64'(iq_size), 64'd0);

      // push 3 / pop 2 at count 5
      pp(4, 0, 64'h400);
      pp(1, 0, 64'h404);
      chk("t4_left5", 64'(iq_size_left), 64'd11);
      pp(3, 2, 64'h405);
      chk("t4_left", 64'(iq_size_left), 64'd10);
      chk("t4_slot0", out_data[63:0], 64'h402);
      chk("t4_slot1", out_data[127:64], 64'h403);

      // underflow at count 1
      pp(0, 2, 64'h0);
      pp(0, 2, 64'h0);
      pp(0, 1, 64'h0);
      chk("t5_size1", 64'(iq_size), 64'd1);
      chk("t5_slot0", out_data[63:0], 64'h407);
      chk("t5_udf0", 64'(pop_underflow), 64'd0);
      pp(0, 2, 64'h0);
      chk("t5_udf", 64'(pop_underflow), 64'd1);
      chk("t5_size", 64'(iq_size), 64'd0);
      chk("t5_left", 64'(iq_size_left), 64'd16);

      // flush at count 9 with push and pop asserted
      pp(4, 0, 64'h600);
      pp(4, 0, 64'h604);
      pp(1, 0, 64'h608);
      chk("t6_left9", 64'(iq_size_left), 64'd7);
      chk("t6_peak9", 64'(peak_count), 64'd9);
      pp(4, 2, 64'h700, 1'b1);
      chk("t6_fl_left", 64'(iq_size_left), 64'd16);
      chk("t6_fl_size", 64'(iq_size), 64'd0);
      chk("t6_fl_peak", 64'(peak_count), 64'd0);
      chk("t6_fl_udf", 64'(pop_underflow), 64'd1);
      pp(1, 0, 64'h800);
      chk("t6_post_size", 64'(iq_size), 64'd1);
      chk("t6_post_slot0", out_data[63:0], 64'h800);
      chk("t6_post_peak", 64'(peak_count), 64'd1);

      // async reset mid-burst
      pp(4, 0, 64'h900);
      in_data_number  = 3'd4;
      out_data_number = 2'd1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_left", 64'(iq_size_left), 64'd16);
      chk("ar_size", 64'(iq_size), 64'd0);
      chk("ar_out0", out_data[63:0], 64'd0);
      chk("ar_out1", out_data[127:64], 64'd0);
      chk("ar_udf", 64'(pop_underflow), 64'd0);
      chk("ar_peak", 64'(peak_count), 64'd0);
      in_data_number  = '0;
      out_data_number = '0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
